// File: rtl/priority_interrupt_controller_if.sv
// priority_interrupt_controller_if: request/grant bus between interrupt sources and the controller
interface priority_interrupt_controller_if;
  logic       EN;
  logic [3:0] irq;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] Y;
  logic       Valid;
  logic [3:0] pending;
  logic       timeout;
  modport master (output EN, irq, mask, ack, input Y, Valid, pending, timeout);
  modport slave  (input EN, irq, mask, ack, output Y, Valid, pending, timeout);
endinterface

// File: rtl/priority_interrupt_controller.sv
// priority_interrupt_controller: 4-line edge-latched interrupt arbiter with ack/timeout release
module priority_interrupt_controller #(
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  priority_interrupt_controller_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);
  state_t     state_q, state_d;
  logic [1:0] y_q, y_d;
  logic       valid_q, valid_d, to_q, to_d, to_hit;
  logic [3:0] pend_q, pend_d, irq_q, rise, cand, clr;
  logic [7:0] cnt_q, cnt_d;
  // next-state: latch rising edges, pick highest unmasked line in IDLE, release on EN drop/ack/timeout
  always_comb begin
    rise    = bus.irq & ~irq_q;
    cand    = pend_q & ~bus.mask;
    to_hit  = (TIMEOUT != 0) && (cnt_q == LIM);
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    clr     = 4'b0000;
    if (state_q == IDLE) begin
      if (bus.EN && cand != 4'b0000) begin
        state_d = GRANT;
        valid_d = 1'b1;
        cnt_d   = 8'd0;
        y_d     = cand[3] ? 2'd3 : cand[2] ? 2'd2 : cand[1] ? 2'd1 : 2'd0;
      end
    end else if (!bus.EN || bus.ack || to_hit) begin
      state_d = IDLE;
      valid_d = 1'b0;
      y_d     = 2'd0;
      cnt_d   = 8'd0;
      clr     = bus.EN ? (4'b0001 << y_q) : 4'b0000;
      to_d    = bus.EN && !bus.ack;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    pend_d = (pend_q & ~clr) | rise;
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= 2'd0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      pend_q  <= 4'b0000;
      irq_q   <= 4'b0000;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
      irq_q   <= bus.irq;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.Y       = y_q;
  assign bus.Valid   = valid_q;
  assign bus.pending = pend_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_priority_interrupt_controller.sv
// tb_priority_interrupt_controller: directed + random checks against a behavioural arbiter model
module tb_priority_interrupt_controller;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  priority_interrupt_controller_if bus ();
  priority_interrupt_controller #(.TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  bit [3:0] m_pend, m_prev;
  bit       m_busy, m_to;
  int       m_line, m_wait;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_prev = 0; m_busy = 0; m_to = 0; m_line = 0; m_wait = 0;
  endtask

  // One clock of the reference: a grant lives until ack, EN loss, or T cycles spent unacknowledged
  task automatic model_step();
    bit [3:0] cand, clear, rises;
    rises = bus.irq & ~m_prev;
    clear = 0;
    m_to  = 0;
    cand  = m_pend & ~bus.mask;
    if (m_busy) begin
      if (!bus.EN) m_busy = 0;
      else if (bus.ack) begin clear[m_line] = 1; m_busy = 0; end
      else if (T != 0 && m_wait + 1 >= T) begin clear[m_line] = 1; m_busy = 0; m_to = 1; end
      else m_wait++;
    end else if (bus.EN && cand != 0) begin
      for (int i = 0; i < 4; i++) if (cand[i]) m_line = i;
      m_busy = 1;
      m_wait = 0;
    end
    m_pend = (m_pend & ~clear) | rises;
    m_prev = bus.irq;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("Y", 8'(bus.Y), m_busy ? 8'(m_line) : 8'd0);
      chk("Valid", 8'(bus.Valid), 8'(m_busy));
      chk("pending", 8'(bus.pending), 8'(m_pend));
      chk("timeout", 8'(bus.timeout), 8'(m_to));
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] irq, input logic [3:0] mask, input logic ack);
    bus.EN = en; bus.irq = irq; bus.mask = mask; bus.ack = ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_Y", 8'(bus.Y), 8'd0);
    chk("rst_Valid", 8'(bus.Valid), 8'd0);
    chk("rst_pending", 8'(bus.pending), 8'd0);
    chk("rst_timeout", 8'(bus.timeout), 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    drive(1, 4'b0000, 4'b0000, 0);
    model_reset();
    @(posedge clk); #1;
    do_reset();
    // single line 2 with ack
    drive(1, 4'b0100, 4'b0000, 0); cyc(1);
    chk("s34_pend", 8'(bus.pending), 8'h4);
    cyc(1);
    chk("s34_y", 8'(bus.Y), 8'd2);
    bus.ack = 1; cyc(1); bus.ack = 0;
    chk("s34_clr", 8'(bus.pending), 8'h0);
    drive(1, 4'b0000, 4'b0000, 0); cyc(1);
    // two lines: 3 then 1
    drive(1, 4'b1010, 4'b0000, 0); cyc(2);
    chk("s35_y3", 8'(bus.Y), 8'd3);
    bus.ack = 1; cyc(1); bus.ack = 0;
    chk("s35_idle", 8'(bus.Valid), 8'd0);
    cyc(1);
    chk("s35_y1", 8'(bus.Y), 8'd1);
    bus.ack = 1; cyc(1); bus.ack = 0;
    chk("s35_clr", 8'(bus.pending), 8'h0);
    drive(1, 4'b0000, 4'b0000, 0); cyc(1);
    // timeout on line 0
    drive(1, 4'b0001, 4'b0000, 0); cyc(2);
    cyc(3);
    chk("s36_hold", 8'(bus.Valid), 8'd1);
    cyc(1);
    chk("s36_to", 8'(bus.timeout), 8'd1);
    chk("s36_pend", 8'(bus.pending), 8'h0);
    cyc(1);
    chk("s36_pulse", 8'(bus.timeout), 8'd0);
    drive(1, 4'b0000, 4'b0000, 0); cyc(1);
    // masked line 3
    drive(1, 4'b1001, 4'b1000, 0); cyc(2);
    chk("s37_y0", 8'(bus.Y), 8'd0);
    bus.ack = 1; cyc(1); bus.ack = 0; bus.mask = 4'b0000;
    cyc(1);
    chk("s37_y3", 8'(bus.Y), 8'd3);
    bus.ack = 1; cyc(1); bus.ack = 0;
    drive(1, 4'b0000, 4'b0000, 0); cyc(1);
    // EN drop mid-grant
    drive(1, 4'b0100, 4'b0000, 0); cyc(2);
    bus.EN = 0; cyc(1);
    chk("s38_drop", 8'(bus.Valid), 8'd0);
    chk("s38_keep", 8'(bus.pending), 8'h4);
    bus.EN = 1; cyc(1);
    chk("s38_regrant", 8'(bus.Y), 8'd2);
    bus.ack = 1; cyc(1); bus.ack = 0;
    drive(1, 4'b0000, 4'b0000, 0); cyc(1);
    // new edge collides with ack
    drive(1, 4'b0010, 4'b0000, 0); cyc(2);
    bus.irq = 4'b0000; cyc(1);
    bus.irq = 4'b0010; bus.ack = 1; cyc(1); bus.ack = 0;
    chk("s39_keep", 8'(bus.pending), 8'h2);
    cyc(1);
    chk("s39_regrant", 8'(bus.Y), 8'd1);
    bus.ack = 1; cyc(1); bus.ack = 0;
    // reset mid-grant with irq held high
    drive(1, 4'b0100, 4'b0000, 0); cyc(2);
    do_reset();
    cyc(1);
    chk("s33_pend", 8'(bus.pending), 8'h4);
    cyc(3);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      bus.irq  = 4'($urandom);
      bus.ack  = ($urandom_range(0, 9) < 3);
      bus.EN   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) bus.mask = 4'($urandom);
      cyc(1);
      if (k == 200) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
